bti_mux: RTL and testbench
==========================

BTI_MUX -- requirements
Module: bti_mux

Interface
REQ-001 SHALL have parameter N_CH, default 2, meaning number of upstream request/response channels; legal range 2..8.
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have parameter DW, default 32, meaning data width; strobe width is DW/8.
REQ-004 SHALL have parameter MAX_OS, default 4, meaning the maximum number of outstanding downstream transactions; power of 2, range 2..16.
REQ-005 SHALL use one clock and a synchronous, active-high reset: port clk, input, 1 bit, rising-edge clock; port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port ch_req_vld, input, N_CH bits: per-channel request valid.
REQ-007 SHALL have port ch_req_rdy, output, N_CH bits: per-channel request ready.
REQ-008 SHALL have port ch_req_wr, input, N_CH bits: per-channel write (1) / read (0).
REQ-009 SHALL have ports ch_req_addr (input, N_CH*AW), ch_req_wdata (input, N_CH*DW) and ch_req_strb (input, N_CH*DW/8): packed per-channel payload, with channel i at slice i.
REQ-010 SHALL have ports ch_rsp_vld (output, N_CH), ch_rsp_rdy (input, N_CH) and ch_rsp_rdata (output, DW): per-channel response handshake plus shared read data.
REQ-011 SHALL have ports m_req_vld (output, 1), m_req_rdy (input, 1), m_req_wr (output, 1), m_req_addr (output, AW), m_req_wdata (output, DW) and m_req_strb (output, DW/8): downstream BTI request.
REQ-012 SHALL have ports m_rsp_vld (input, 1), m_rsp_rdy (output, 1) and m_rsp_rdata (input, DW): downstream BTI response.
REQ-013 SHALL have port err_unexp_rsp, output, 1 bit: sticky flag for a response received with no outstanding transaction.

Function
REQ-014 SHALL select one requesting channel per cycle and drive m_req_* combinationally from that channel's payload, adding zero cycles of request latency.
REQ-015 SHALL accept a request only when m_req_vld, m_req_rdy and "tracking FIFO not full" are all true in the same cycle; ch_req_rdy[i] = grant[i] & m_req_rdy & ~full.
REQ-016 SHALL deassert m_req_vld whenever the tracking FIFO is full, even if channels are requesting.
REQ-017 SHALL hold the grant on a channel after m_req_vld is shown and not yet accepted, so the downstream sees a stable request until the handshake completes.
REQ-018 SHALL push the granted channel id (width clog2(N_CH)) into a MAX_OS-deep in-order tracking FIFO on each accepted request.
REQ-019 SHALL route each downstream response to the channel at the FIFO head: ch_rsp_vld[head] = m_rsp_vld & ~empty; m_rsp_rdy = ch_rsp_rdy[head] & ~empty; ch_rsp_rdata = m_rsp_rdata.
REQ-020 SHALL pop the FIFO on each m_rsp_vld & m_rsp_rdy handshake.
REQ-021 SHALL leave the occupancy count unchanged on a same-cycle push and pop, including when the FIFO is full.
REQ-022 SHALL wrap the FIFO pointers modulo MAX_OS and track occupancy in clog2(MAX_OS)+1 bits.
REQ-023 SHALL, when m_rsp_vld is asserted with the FIFO empty, hold m_rsp_rdy at 0 and set err_unexp_rsp to 1 on the next edge, where it stays until reset.

Reset
REQ-024 SHALL, when rst is high at a clock edge, empty the FIFO, set the arbitration pointer to 0, release the grant hold and clear err_unexp_rsp.
REQ-025 SHALL, as a consequence of REQ-024, present m_req_vld=0, ch_req_rdy=0, ch_rsp_vld=0 and m_rsp_rdy=0 in the cycle after reset.
REQ-026 SHALL discard all in-flight transactions when reset is applied mid-operation; any late downstream responses then set err_unexp_rsp.

Configuration
REQ-027 SHALL, with macro BTI_MUX_RR_EN defined, arbitrate round-robin: search starts at the channel after the last accepted one, and the pointer advances only on an accepted request.
REQ-028 SHALL, with BTI_MUX_RR_EN undefined, arbitrate by fixed priority with channel 0 highest and no pointer state; REQ-017 applies in both builds.

Verification
REQ-029 SHALL be covered by: N_CH=2, ch0 and ch1 valid continuously, m_req_rdy=1, BTI_MUX_RR_EN defined -> accepted sequence 0,1,0,1; with the macro undefined -> 0,0,0,0.
REQ-030 SHALL be covered by: MAX_OS=4, 4 requests accepted with no responses -> m_req_vld=0 and ch_req_rdy=0; one response returned -> m_req_vld reasserts the same cycle the pop completes.
REQ-031 SHALL be covered by: requests ch1 (addr 0x100), ch0 (addr 0x200), ch1 (addr 0x300), then responses 0xA, 0xB, 0xC -> ch1 gets 0xA, ch0 gets 0xB, ch1 gets 0xC, in order.
REQ-032 SHALL be covered by: m_req_rdy=0 for 3 cycles while ch0 is granted and ch1 raises valid -> m_req_addr stays at ch0's value until accepted.
REQ-033 SHALL be covered by: m_rsp_vld=1 with the FIFO empty -> m_rsp_rdy=0 and err_unexp_rsp=1 next cycle; then rst pulse -> err_unexp_rsp=0.
REQ-034 SHALL be covered by: FIFO full with push and pop in the same cycle -> occupancy stays 4 and the pushed id appears at the correct position after wrap.

Source files
------------

// File: rtl/bti_mux.sv
// bti_mux: N_CH-to-1 BTI request multiplexer with in-order response routing.
// Requests are arbitrated and forwarded combinationally. Each accepted request
// pushes its channel id into a MAX_OS-deep FIFO, and the FIFO head steers
// downstream responses back to the channel that issued the request.
// Optional macro BTI_MUX_RR_EN: round-robin arbitration (default: fixed
// priority, channel 0 highest).
module bti_mux #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned MAX_OS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  // upstream channels
  input  logic [N_CH-1:0]          ch_req_vld,
  output logic [N_CH-1:0]          ch_req_rdy,
  input  logic [N_CH-1:0]          ch_req_wr,
  input  logic [N_CH*AW-1:0]       ch_req_addr,
  input  logic [N_CH*DW-1:0]       ch_req_wdata,
  input  logic [N_CH*(DW/8)-1:0]   ch_req_strb,
  output logic [N_CH-1:0]          ch_rsp_vld,
  input  logic [N_CH-1:0]          ch_rsp_rdy,
  output logic [DW-1:0]            ch_rsp_rdata,
  // downstream port
  output logic                     m_req_vld,
  input  logic                     m_req_rdy,
  output logic                     m_req_wr,
  output logic [AW-1:0]            m_req_addr,
  output logic [DW-1:0]            m_req_wdata,
  output logic [DW/8-1:0]          m_req_strb,
  input  logic                     m_rsp_vld,
  output logic                     m_rsp_rdy,
  input  logic [DW-1:0]            m_rsp_rdata,
  // status
  output logic                     err_unexp_rsp
);

  localparam int unsigned SW   = DW / 8;
  localparam int unsigned IDW  = $clog2(N_CH);
  localparam int unsigned PW   = $clog2(MAX_OS);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned SUMW = IDW + 1;

  // Per-channel payload views of the packed input buses
  logic [AW-1:0] addr_a  [N_CH];
  logic [DW-1:0] wdata_a [N_CH];
  logic [SW-1:0] strb_a  [N_CH];

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_unpack
    assign addr_a[g]  = ch_req_addr[g*AW +: AW];
    assign wdata_a[g] = ch_req_wdata[g*DW +: DW];
    assign strb_a[g]  = ch_req_strb[g*SW +: SW];
  end

  // Tracking FIFO and control state
  logic [IDW-1:0] fifo_q [MAX_OS];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           hold_q, hold_d;
  logic [IDW-1:0] hold_id_q, hold_id_d;
  logic           err_q, err_d;
`ifdef BTI_MUX_RR_EN
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  logic           gnt_vld_c;
  logic [IDW-1:0] gnt_id_c;
  logic [IDW-1:0] head_c;
  logic           empty_c;
  logic           full_c;
  logic           push_c;
  logic           pop_c;

  // Grant selection: a shown-but-unaccepted request keeps its grant
  always_comb begin
    logic [SUMW-1:0] sum;
    logic [IDW-1:0]  idx;
    gnt_vld_c = 1'b0;
    gnt_id_c  = '0;
    sum       = '0;
    idx       = '0;
    if (hold_q) begin
      gnt_vld_c = ch_req_vld[hold_id_q];
      gnt_id_c  = hold_id_q;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
`ifdef BTI_MUX_RR_EN
        sum = {1'b0, rr_ptr_q} + SUMW'(k);
        if (sum >= SUMW'(N_CH)) begin
          sum = sum - SUMW'(N_CH);
        end
        idx = sum[IDW-1:0];
`else
        sum = SUMW'(k);
        idx = sum[IDW-1:0];
`endif
        if (!gnt_vld_c && ch_req_vld[idx]) begin
          gnt_vld_c = 1'b1;
          gnt_id_c  = idx;
        end
      end
    end
  end

  // FIFO status, handshakes and response steering
  always_comb begin
    empty_c      = (cnt_q == '0);
    head_c       = fifo_q[rd_ptr_q];
    m_rsp_rdy    = ch_rsp_rdy[head_c] & ~empty_c;
    pop_c        = m_rsp_vld & m_rsp_rdy;
    // a same-cycle pop frees a slot, so a full FIFO can still take a push
    full_c       = (cnt_q == CW'(MAX_OS)) & ~pop_c;
    m_req_vld    = gnt_vld_c & ~full_c;
    push_c       = m_req_vld & m_req_rdy;
    ch_rsp_rdata = m_rsp_rdata;
    ch_req_rdy   = '0;
    ch_rsp_vld   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (gnt_vld_c && (gnt_id_c == IDW'(i))) begin
        ch_req_rdy[i] = m_req_rdy & ~full_c;
      end
      if (head_c == IDW'(i)) begin
        ch_rsp_vld[i] = m_rsp_vld & ~empty_c;
      end
    end
  end

  // Downstream request payload from the granted channel
  always_comb begin
    m_req_wr    = ch_req_wr[gnt_id_c];
    m_req_addr  = addr_a[gnt_id_c];
    m_req_wdata = wdata_a[gnt_id_c];
    m_req_strb  = strb_a[gnt_id_c];
  end

  // Next-state logic for pointers, occupancy, grant hold and error flag
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    hold_d    = m_req_vld & ~m_req_rdy;
    hold_id_d = gnt_id_c;
    err_d     = err_q | (m_rsp_vld & empty_c);
`ifdef BTI_MUX_RR_EN
    rr_ptr_d  = rr_ptr_q;
    if (push_c) begin
      rr_ptr_d = (gnt_id_c == IDW'(N_CH - 1)) ? '0 : gnt_id_c + IDW'(1);
    end
`endif
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      hold_q    <= 1'b0;
      hold_id_q <= '0;
      err_q     <= 1'b0;
`ifdef BTI_MUX_RR_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
      err_q     <= err_d;
`ifdef BTI_MUX_RR_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push_c && !rst) begin
      fifo_q[wr_ptr_q] <= gnt_id_c;
    end
  end

  assign err_unexp_rsp = err_q;

endmodule

// File: tb/tb_bti_mux.sv
// Self-checking bench for bti_mux (default parameters). Expected behaviour of
// the arbitration depends on BTI_MUX_RR_EN, mirrored here with the same macro.
module tb_bti_mux;

  localparam int unsigned N_CH   = 2;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned MAX_OS = 4;
  localparam int unsigned SW     = DW / 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       ch_req_vld;
  logic [N_CH-1:0]       ch_req_rdy;
  logic [N_CH-1:0]       ch_req_wr;
  logic [N_CH*AW-1:0]    ch_req_addr;
  logic [N_CH*DW-1:0]    ch_req_wdata;
  logic [N_CH*SW-1:0]    ch_req_strb;
  logic [N_CH-1:0]       ch_rsp_vld;
  logic [N_CH-1:0]       ch_rsp_rdy;
  logic [DW-1:0]         ch_rsp_rdata;
  logic                  m_req_vld;
  logic                  m_req_rdy;
  logic                  m_req_wr;
  logic [AW-1:0]         m_req_addr;
  logic [DW-1:0]         m_req_wdata;
  logic [SW-1:0]         m_req_strb;
  logic                  m_rsp_vld;
  logic                  m_rsp_rdy;
  logic [DW-1:0]         m_rsp_rdata;
  logic                  err_unexp_rsp;

  int n_chk  = 0;
  int n_pass = 0;

  bti_mux #(.N_CH(N_CH), .AW(AW), .DW(DW), .MAX_OS(MAX_OS)) dut (
    .clk(clk), .rst(rst),
    .ch_req_vld(ch_req_vld), .ch_req_rdy(ch_req_rdy), .ch_req_wr(ch_req_wr),
    .ch_req_addr(ch_req_addr), .ch_req_wdata(ch_req_wdata), .ch_req_strb(ch_req_strb),
    .ch_rsp_vld(ch_rsp_vld), .ch_rsp_rdy(ch_rsp_rdy), .ch_rsp_rdata(ch_rsp_rdata),
    .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_wr(m_req_wr),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_strb(m_req_strb),
    .m_rsp_vld(m_rsp_vld), .m_rsp_rdy(m_rsp_rdy), .m_rsp_rdata(m_rsp_rdata),
    .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  int          mq[$];        // channel ids of outstanding transactions, oldest first
  int          m_rr;         // next round-robin search start
  bit          m_hold;
  int          m_hold_id;
  bit          m_err;
  bit          e_empty, e_pop, e_full, e_gvld, e_mvld, e_push, e_mrsp_rdy;
  int          e_gid, e_head;
  logic [N_CH-1:0] e_ch_req_rdy, e_ch_rsp_vld;

  function automatic int model_pick(input logic [N_CH-1:0] v);
    for (int k = 0; k < int'(N_CH); k++) begin
`ifdef BTI_MUX_RR_EN
      if (v[(m_rr + k) % N_CH]) return (m_rr + k) % N_CH;
`else
      if (v[k]) return k;
`endif
    end
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_hold = 0; m_hold_id = 0; m_err = 0;
  endtask

  task automatic model_eval();
    e_empty      = (mq.size() == 0);
    e_head       = e_empty ? 0 : mq[0];
    e_mrsp_rdy   = !e_empty && ch_rsp_rdy[e_head];
    e_ch_rsp_vld = (m_rsp_vld && !e_empty) ? (N_CH'(1) << e_head) : '0;
    e_pop        = m_rsp_vld && e_mrsp_rdy;
    e_full       = (mq.size() == MAX_OS) && !e_pop;
    e_gid        = m_hold ? m_hold_id : model_pick(ch_req_vld);
    e_gvld       = (e_gid >= 0);
    e_mvld       = e_gvld && !e_full;
    e_push       = e_mvld && m_req_rdy;
    e_ch_req_rdy = (e_gvld && m_req_rdy && !e_full) ? (N_CH'(1) << e_gid) : '0;
  endtask

  task automatic model_commit();
    if (e_pop) void'(mq.pop_front());
    if (e_push) begin
      mq.push_back(e_gid);
      m_rr = (e_gid + 1) % N_CH;
    end
    m_hold    = e_mvld && !m_req_rdy;
    m_hold_id = e_gid;
    if (m_rsp_vld && e_empty) m_err = 1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    ch_req_vld = '0; ch_req_wr = '0; ch_req_addr = '0; ch_req_wdata = '0;
    ch_req_strb = '0; ch_rsp_rdy = '0; m_req_rdy = 1'b0; m_rsp_vld = 1'b0;
    m_rsp_rdata = '0;
  endtask

  task automatic set_req(input int ch, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    ch_req_addr[ch*AW +: AW]  = a;
    ch_req_wdata[ch*DW +: DW] = d;
    ch_req_strb[ch*SW +: SW]  = s;
    ch_req_wr[ch]             = w;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    n_chk++; if (m_req_vld !== 1'b0) $display("FAIL rst_m_req_vld got %b exp 0", m_req_vld); else n_pass++;
    n_chk++; if (ch_req_rdy !== 2'b00) $display("FAIL rst_ch_req_rdy got %b exp 00", ch_req_rdy); else n_pass++;
    n_chk++; if (ch_rsp_vld !== 2'b00) $display("FAIL rst_ch_rsp_vld got %b exp 00", ch_rsp_vld); else n_pass++;
    n_chk++; if (m_rsp_rdy !== 1'b0) $display("FAIL rst_m_rsp_rdy got %b exp 0", m_rsp_rdy); else n_pass++;
    n_chk++; if (err_unexp_rsp !== 1'b0) $display("FAIL rst_err got %b exp 0", err_unexp_rsp); else n_pass++;
  endtask

  // both channels valid: arbitration order, fill to MAX_OS, then pop reopens
  task automatic test_arbitration();
    int exp_ch;
    logic [AW-1:0] exp_a;
    apply_reset();
    @(negedge clk);
    ch_req_vld = 2'b11; m_req_rdy = 1'b1;
    set_req(0, 32'h10, 1'b0, '0, '0);
    set_req(1, 32'h20, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
`ifdef BTI_MUX_RR_EN
      exp_ch = k % 2;
`else
      exp_ch = 0;
`endif
      exp_a = (exp_ch == 0) ? 32'h10 : 32'h20;
      n_chk++; if (m_req_addr !== exp_a) $display("FAIL arb_addr[%0d] got %h exp %h", k, m_req_addr, exp_a); else n_pass++;
      n_chk++; if (ch_req_rdy !== N_CH'(1) << exp_ch) $display("FAIL arb_rdy[%0d] got %b exp %b", k, ch_req_rdy, N_CH'(1) << exp_ch); else n_pass++;
    end
    @(negedge clk); #1;
    n_chk++; if (m_req_vld !== 1'b0) $display("FAIL full_m_req_vld got %b exp 0", m_req_vld); else n_pass++;
    n_chk++; if (ch_req_rdy !== 2'b00) $display("FAIL full_ch_req_rdy got %b exp 00", ch_req_rdy); else n_pass++;
    @(negedge clk);
    m_rsp_vld = 1'b1; ch_rsp_rdy = 2'b11; m_rsp_rdata = 32'h55;
    #1;
    n_chk++; if (m_rsp_rdy !== 1'b1) $display("FAIL pop_m_rsp_rdy got %b exp 1", m_rsp_rdy); else n_pass++;
    n_chk++; if (ch_rsp_vld !== 2'b01) $display("FAIL pop_ch_rsp_vld got %b exp 01", ch_rsp_vld); else n_pass++;
    n_chk++; if (m_req_vld !== 1'b1) $display("FAIL pop_reopen_m_req_vld got %b exp 1", m_req_vld); else n_pass++;
    n_chk++; if (ch_req_rdy !== 2'b01) $display("FAIL pop_reopen_rdy got %b exp 01", ch_req_rdy); else n_pass++;
  endtask

  // requests ch1,ch0,ch1 then responses A,B,C route in issue order
  task automatic test_order();
    int          ids [3] = '{1, 0, 1};
    logic [31:0] adr [3] = '{32'h100, 32'h200, 32'h300};
    logic [31:0] rd  [3] = '{32'hA, 32'hB, 32'hC};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      m_req_rdy = 1'b1;
      ch_req_vld[ids[k]] = 1'b1;
      set_req(ids[k], adr[k], 1'b1, 32'hD00 + k, 4'h3);
      #1;
      n_chk++; if (m_req_addr !== adr[k]) $display("FAIL ord_addr[%0d] got %h exp %h", k, m_req_addr, adr[k]); else n_pass++;
      n_chk++; if ({m_req_wr, m_req_strb, m_req_wdata} !== {1'b1, 4'h3, 32'hD00 + k})
        $display("FAIL ord_payload[%0d] got %h exp %h", k, {m_req_wr, m_req_strb, m_req_wdata}, {1'b1, 4'h3, 32'hD00 + k}); else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      m_rsp_vld = 1'b1; ch_rsp_rdy = 2'b11; m_rsp_rdata = rd[k];
      #1;
      n_chk++; if (ch_rsp_vld !== N_CH'(1) << ids[k]) $display("FAIL ord_rsp_vld[%0d] got %b exp %b", k, ch_rsp_vld, N_CH'(1) << ids[k]); else n_pass++;
      n_chk++; if (ch_rsp_rdata !== rd[k]) $display("FAIL ord_rdata[%0d] got %h exp %h", k, ch_rsp_rdata, rd[k]); else n_pass++;
    end
    @(negedge clk); idle(); #1;
    n_chk++; if (err_unexp_rsp !== 1'b0) $display("FAIL ord_err got %b exp 0", err_unexp_rsp); else n_pass++;
  endtask

  // stalled request keeps its grant while the other channel raises valid
  task automatic test_hold();
    for (int first = 0; first < 2; first++) begin
      logic [AW-1:0] fa;
      apply_reset();
      fa = (first == 0) ? 32'h200 : 32'h300;
      set_req(0, 32'h200, 1'b0, '0, '0);
      set_req(1, 32'h300, 1'b0, '0, '0);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        ch_req_vld = (c == 0) ? N_CH'(1) << first : 2'b11;
        m_req_rdy  = (c == 3);
        #1;
        n_chk++; if (m_req_addr !== fa) $display("FAIL hold%0d_addr[%0d] got %h exp %h", first, c, m_req_addr, fa); else n_pass++;
        n_chk++; if (ch_req_rdy !== ((c == 3) ? N_CH'(1) << first : 2'b00))
          $display("FAIL hold%0d_rdy[%0d] got %b", first, c, ch_req_rdy); else n_pass++;
      end
    end
  endtask

  // unexpected response flag, stickiness, and clearing/resetting mid-operation
  task automatic test_unexpected();
    apply_reset();
    @(negedge clk);
    m_rsp_vld = 1'b1; ch_rsp_rdy = 2'b11;
    #1;
    n_chk++; if (m_rsp_rdy !== 1'b0) $display("FAIL unexp_m_rsp_rdy got %b exp 0", m_rsp_rdy); else n_pass++;
    n_chk++; if (ch_rsp_vld !== 2'b00) $display("FAIL unexp_ch_rsp_vld got %b exp 00", ch_rsp_vld); else n_pass++;
    @(negedge clk); m_rsp_vld = 1'b0; #1;
    n_chk++; if (err_unexp_rsp !== 1'b1) $display("FAIL unexp_err_set got %b exp 1", err_unexp_rsp); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (err_unexp_rsp !== 1'b1) $display("FAIL unexp_err_sticky got %b exp 1", err_unexp_rsp); else n_pass++;
    apply_reset(); #1;
    n_chk++; if (err_unexp_rsp !== 1'b0) $display("FAIL unexp_err_clr got %b exp 0", err_unexp_rsp); else n_pass++;
    // two in flight, then reset discards them
    @(negedge clk);
    ch_req_vld = 2'b01; m_req_rdy = 1'b1;
    @(negedge clk);
    apply_reset();
    m_rsp_vld = 1'b1; ch_rsp_rdy = 2'b11;
    #1;
    n_chk++; if (m_rsp_rdy !== 1'b0) $display("FAIL late_m_rsp_rdy got %b exp 0", m_rsp_rdy); else n_pass++;
    @(negedge clk); m_rsp_vld = 1'b0; #1;
    n_chk++; if (err_unexp_rsp !== 1'b1) $display("FAIL late_err got %b exp 1", err_unexp_rsp); else n_pass++;
  endtask

  // full FIFO with push and pop in the same cycle; pushed id lands after wrap
  task automatic test_full_push_pop();
    int fill [4] = '{0, 1, 1, 0};
    int drain[4] = '{1, 1, 0, 1};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle(); m_req_rdy = 1'b1; ch_req_vld[fill[k]] = 1'b1;
    end
    @(negedge clk);
    idle();
    ch_req_vld = 2'b10; m_req_rdy = 1'b1; m_rsp_vld = 1'b1; ch_rsp_rdy = 2'b11;
    #1;
    n_chk++; if (m_req_vld !== 1'b1) $display("FAIL fpp_m_req_vld got %b exp 1", m_req_vld); else n_pass++;
    n_chk++; if (ch_req_rdy !== 2'b10) $display("FAIL fpp_ch_req_rdy got %b exp 10", ch_req_rdy); else n_pass++;
    n_chk++; if (ch_rsp_vld !== 2'b01) $display("FAIL fpp_ch_rsp_vld got %b exp 01", ch_rsp_vld); else n_pass++;
    @(negedge clk);
    idle(); ch_req_vld = 2'b01; m_req_rdy = 1'b1;
    #1;
    n_chk++; if (m_req_vld !== 1'b0) $display("FAIL fpp_still_full got %b exp 0", m_req_vld); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle(); m_rsp_vld = 1'b1; ch_rsp_rdy = 2'b11;
      #1;
      n_chk++; if (ch_rsp_vld !== N_CH'(1) << drain[k]) $display("FAIL fpp_drain[%0d] got %b exp %b", k, ch_rsp_vld, N_CH'(1) << drain[k]); else n_pass++;
    end
    @(negedge clk); idle();
  endtask

  // random traffic against the transaction-level model
  task automatic test_random();
    logic [AW-1:0] ra [N_CH];
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < int'(N_CH); ch++) begin
        if (m_hold && m_hold_id == ch) begin
          ch_req_vld[ch] = 1'b1;
        end else begin
          ch_req_vld[ch] = 1'($urandom_range(0, 1));
          ra[ch] = $urandom;
          set_req(ch, ra[ch], 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
        end
      end
      m_req_rdy   = ($urandom_range(0, 3) != 0);
      ch_rsp_rdy  = N_CH'($urandom);
      m_rsp_vld   = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
      m_rsp_rdata = $urandom;
      #1;
      model_eval();
      n_chk++; if (m_req_vld !== e_mvld) $display("FAIL rnd_m_req_vld c%0d got %b exp %b", c, m_req_vld, e_mvld); else n_pass++;
      if (e_mvld) begin
        n_chk++; if (m_req_addr !== ra[e_gid]) $display("FAIL rnd_addr c%0d got %h exp %h", c, m_req_addr, ra[e_gid]); else n_pass++;
      end
      n_chk++; if (ch_req_rdy !== e_ch_req_rdy) $display("FAIL rnd_ch_req_rdy c%0d got %b exp %b", c, ch_req_rdy, e_ch_req_rdy); else n_pass++;
      n_chk++; if (ch_rsp_vld !== e_ch_rsp_vld) $display("FAIL rnd_ch_rsp_vld c%0d got %b exp %b", c, ch_rsp_vld, e_ch_rsp_vld); else n_pass++;
      n_chk++; if (m_rsp_rdy !== e_mrsp_rdy) $display("FAIL rnd_m_rsp_rdy c%0d got %b exp %b", c, m_rsp_rdy, e_mrsp_rdy); else n_pass++;
      n_chk++; if (ch_rsp_rdata !== m_rsp_rdata) $display("FAIL rnd_rdata c%0d got %h exp %h", c, ch_rsp_rdata, m_rsp_rdata); else n_pass++;
      n_chk++; if (err_unexp_rsp !== m_err) $display("FAIL rnd_err c%0d got %b exp %b", c, err_unexp_rsp, m_err); else n_pass++;
      model_commit();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_arbitration();
    test_order();
    test_hold();
    test_unexpected();
    test_full_push_pop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
